// File: rtl/write_back_pkg.sv
// Shared cache definitions: geometry constants and the FSM state
// encoding used by both the line write-back and line refill blocks.
package write_back_pkg;

    localparam int INDEX_W    = 6;
    localparam int OFFS_W     = 3;
    localparam int TAG_W      = 4;
    localparam int MEM_AW     = TAG_W + INDEX_W + OFFS_W;
    localparam int CACHE_AW   = INDEX_W + OFFS_W;
    localparam int LINE_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/write_back.sv
// Evicts one 8-word cache line into main memory at the victim address.
// Ports: clk/rst (sync, active high); CPU_addr, victim_tag, start in;
// cache_data_addr out / cache_data_dout in (1-cycle sync RAM);
// main_mem_addr, main_mem_din, main_mem_we out; busy, done status.
module write_back
    import write_back_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         CPU_addr,
    input  logic [TAG_W-1:0]    victim_tag,
    input  logic                start,
    output logic [CACHE_AW-1:0] cache_data_addr,
    input  logic [31:0]         cache_data_dout,
    output logic [MEM_AW-1:0]   main_mem_addr,
    output logic [31:0]         main_mem_din,
    output logic                main_mem_we,
    output logic                busy,
    output logic                done
);

    state_t              state, state_d;
    logic [OFFS_W-1:0]   cnt, cnt_d;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CACHE_AW-1:0] caddr_d;
    logic [MEM_AW-1:0]   maddr_d;
    logic                we_d;
    logic                done_d;

    // Only the index field of the CPU address matters here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{CPU_addr[31:11], CPU_addr[4:0]};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx_q;
        tag_d   = tag_q;
        caddr_d = cache_data_addr;
        maddr_d = main_mem_addr;
        we_d    = main_mem_we;
        done_d  = done;
        unique case (state)
            IDLE: begin
                done_d = 1'b0;
                we_d   = 1'b0;
                if (start) begin
                    idx_d   = CPU_addr[10:5];
                    tag_d   = victim_tag;
                    caddr_d = {CPU_addr[10:5], {OFFS_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                // RAM already holds word 0's address; prime word 1.
                caddr_d = {idx_q, OFFS_W'(1)};
                maddr_d = {tag_q, idx_q, {OFFS_W{1'b0}}};
                we_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d   = cnt + OFFS_W'(1);
                maddr_d = {tag_q, idx_q, cnt + OFFS_W'(1)};
                // Read address runs two words ahead of the write.
                if (cnt <= OFFS_W'(5))
                    caddr_d = {idx_q, cnt + OFFS_W'(2)};
                if (cnt == OFFS_W'(LINE_WORDS - 1)) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx_q           <= '0;
            tag_q           <= '0;
            cache_data_addr <= '0;
            main_mem_addr   <= '0;
            main_mem_we     <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            idx_q           <= idx_d;
            tag_q           <= tag_d;
            cache_data_addr <= caddr_d;
            main_mem_addr   <= maddr_d;
            main_mem_we     <= we_d;
            done            <= done_d;
        end
    end

    assign busy         = (state != IDLE);
    assign main_mem_din = cache_data_dout;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: sync cache RAM model, memory
// model and a write scoreboard of expected (address, data) pairs.
module tb_write_back;
    import write_back_pkg::*;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         CPU_addr;
    logic [TAG_W-1:0]    victim_tag;
    logic                start;
    logic [CACHE_AW-1:0] cache_data_addr;
    logic [31:0]         cache_data_dout;
    logic [MEM_AW-1:0]   main_mem_addr;
    logic [31:0]         main_mem_din;
    logic                main_mem_we;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    wr_t sb[$];
    wr_t mon_e;

    logic [31:0] cache_ram [0:(1<<CACHE_AW)-1];
    logic [31:0] mem       [0:(1<<MEM_AW)-1];

    write_back dut (
        .clk             (clk),
        .rst             (rst),
        .CPU_addr        (CPU_addr),
        .victim_tag      (victim_tag),
        .start           (start),
        .cache_data_addr (cache_data_addr),
        .cache_data_dout (cache_data_dout),
        .main_mem_addr   (main_mem_addr),
        .main_mem_din    (main_mem_din),
        .main_mem_we     (main_mem_we),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cache_data_dout <= cache_ram[cache_data_addr];

    always @(posedge clk) if (main_mem_we === 1'b1) mem[main_mem_addr] <= main_mem_din;

    // Scoreboard: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (main_mem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h",
                         main_mem_addr, main_mem_din);
            end else begin
                mon_e = sb.pop_front();
                if (main_mem_addr !== mon_e.addr || main_mem_din !== mon_e.data) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             main_mem_addr, main_mem_din, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push_line(input logic [INDEX_W-1:0] idx,
                             input logic [TAG_W-1:0] tag);
        for (int o = 0; o < LINE_WORDS; o++) begin
            logic [OFFS_W-1:0] off;
            wr_t e;
            off    = o[OFFS_W-1:0];
            e.addr = {tag, idx, off};
            e.data = cache_ram[{idx, off}];
            sb.push_back(e);
        end
    endtask

    // Leaves the caller at the falling edge of cycle 1.
    task automatic pulse_start(input logic [INDEX_W-1:0] idx,
                               input logic [TAG_W-1:0] tag);
        @(negedge clk);
        CPU_addr   = {21'd0, idx, 5'd0};
        victim_tag = tag;
        start      = 1'b1;
        push_line(idx, tag);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (main_mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl we=%b done=%b busy=%b want 0 0 0",
                     main_mem_we, done, busy);
        end
        checks++;
        if (cache_data_addr !== '0 || main_mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr caddr=%h maddr=%h want 0 0",
                     cache_data_addr, main_mem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pulse_start(6'd5, 4'h3);
        for (int c = 1; c <= 11; c++) begin
            logic ew, ed, eb;
            ew = (c >= 2 && c <= 9);
            ed = (c == 10);
            eb = (c <= 10);
            checks++;
            if (main_mem_we !== ew || done !== ed || busy !== eb) begin
                failures++;
                $display("FAIL basic_timing cycle=%0d we=%b done=%b busy=%b want %b %b %b",
                         c, main_mem_we, done, busy, ew, ed, eb);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL basic_count pending=%0d want 0", sb.size());
        end
        for (int i = 0; i < LINE_WORDS; i++) begin
            checks++;
            if (mem[13'h0628 + i] !== 32'hA0 + i) begin
                failures++;
                $display("FAIL basic_mem word=%0d got=%h want=%h",
                         i, mem[13'h0628 + i], 32'hA0 + i);
            end
        end
    endtask

    task automatic run_to_end(input string name);
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_done got=%b want=1", name, done);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_count pending=%0d want 0", name, sb.size());
        end
    endtask

    task automatic test_boundaries();
        pulse_start(6'd63, 4'hF);
        run_to_end("bound_hi");
        for (int i = 0; i < LINE_WORDS; i++) begin
            checks++;
            if (mem[13'h1FF8 + i] !== cache_ram[504 + i]) begin
                failures++;
                $display("FAIL bound_hi_mem word=%0d got=%h want=%h",
                         i, mem[13'h1FF8 + i], cache_ram[504 + i]);
            end
        end
        pulse_start(6'd0, 4'h0);
        run_to_end("bound_lo");
        for (int i = 0; i < LINE_WORDS; i++) begin
            checks++;
            if (mem[i] !== cache_ram[i]) begin
                failures++;
                $display("FAIL bound_lo_mem word=%0d got=%h want=%h",
                         i, mem[i], cache_ram[i]);
            end
        end
    endtask

    task automatic test_context_latch();
        pulse_start(6'd9, 4'h2);
        CPU_addr   = {21'd0, 6'd40, 5'd0};
        victim_tag = 4'hA;
        run_to_end("latch");
    endtask

    task automatic test_ignored_start();
        pulse_start(6'd12, 4'h5);
        for (int c = 1; c <= 10; c++) begin
            start    = (c == 3 || c == 6 || c == 10);
            CPU_addr = {21'd0, 6'd50, 5'd0};
            if (c == 10) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL ignore_done got=%b want=1", done);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL ignore_idle busy=%b pending=%0d want 0 0",
                     busy, sb.size());
        end
        repeat (3) @(negedge clk);
        pulse_start(6'd13, 4'h6);
        run_to_end("ignore_second");
    endtask

    task automatic test_reset_mid();
        int dones;
        pulse_start(6'd20, 4'h1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (main_mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst we=%b done=%b busy=%b want 0 0 0",
                     main_mem_we, done, busy);
        end
        checks++;
        if (sb.size() != 4) begin
            failures++;
            $display("FAIL midrst_partial pending=%0d want 4", sb.size());
        end
        rst = 1'b0;
        sb.delete();
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midrst_quiet dones=%0d want 0", dones);
        end
        pulse_start(6'd20, 4'h1);
        run_to_end("midrst_fresh");
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        @(negedge clk);
        CPU_addr   = {21'd0, 6'd30, 5'd0};
        victim_tag = 4'h9;
        start      = 1'b1;
        push_line(6'd30, 4'h9);
        push_line(6'd30, 4'h9);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 22) start = 1'b0;
            if (done === 1'b1) done_cyc.push_back(c);
        end
        checks++;
        if (done_cyc.size() != 2) begin
            failures++;
            $display("FAIL b2b_dones got=%0d want=2", done_cyc.size());
        end else begin
            checks++;
            if (done_cyc[0] != 10 || done_cyc[1] - done_cyc[0] != 11) begin
                failures++;
                $display("FAIL b2b_spacing first=%0d gap=%0d want 10 11",
                         done_cyc[0], done_cyc[1] - done_cyc[0]);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        CPU_addr   = '0;
        victim_tag = '0;
        for (int i = 0; i < (1 << CACHE_AW); i++)
            cache_ram[i] = 32'hC0DE_0000 | i;
        for (int i = 0; i < LINE_WORDS; i++)
            cache_ram[40 + i] = 32'hA0 + i;

        test_reset();
        test_basic();
        test_boundaries();
        test_context_latch();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
